// File: rtl/branch_resolve_unit_if.sv
// Handshake bundle for branch_resolve_unit.
// Optional statistics outputs exist when BRANCH_STATS_EN is defined.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
`ifdef BRANCH_STATS_EN
  , parameter int CNT_W = 32
`endif
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      func3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            pred_taken;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_next_pc;
  logic            out_mispredict;
  logic            out_illegal;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_taken;
  logic [CNT_W-1:0] stat_mispredict;

  modport master (
    output in_valid, func3, rs1, rs2, pc, imm,
    output pred_taken, flush, out_ready,
    input  in_ready, out_valid, out_taken,
    input  out_next_pc, out_mispredict, out_illegal,
    input  stat_branches, stat_taken, stat_mispredict
  );

  modport slave (
    input  in_valid, func3, rs1, rs2, pc, imm,
    input  pred_taken, flush, out_ready,
    output in_ready, out_valid, out_taken,
    output out_next_pc, out_mispredict, out_illegal,
    output stat_branches, stat_taken, stat_mispredict
  );
`else
  modport master (
    output in_valid, func3, rs1, rs2, pc, imm,
    output pred_taken, flush, out_ready,
    input  in_ready, out_valid, out_taken,
    input  out_next_pc, out_mispredict, out_illegal
  );

  modport slave (
    input  in_valid, func3, rs1, rs2, pc, imm,
    input  pred_taken, flush, out_ready,
    output in_ready, out_valid, out_taken,
    output out_next_pc, out_mispredict, out_illegal
  );
`endif
endinterface

// File: rtl/branch_resolve_unit.sv
// Pipelined RV32I branch resolution: condition, target, mispredict.
// Define BRANCH_STATS_EN to add branch/taken/mispredict counters.
module branch_resolve_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
`ifdef BRANCH_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input logic                 clk,
  input logic                 rst,
  branch_resolve_unit_if.slave bus
);

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] next_pc;
    logic            mispredict;
    logic            illegal;
  } res_t;

  logic            cond;
  logic            illegal;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fall;
  res_t            res;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  res_t              pay_q [STAGES];
  res_t              pay_d [STAGES];
  logic [STAGES-1:0] rdy;

  // Evaluate the one condition selected by func3, plus both PCs
  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    unique case (bus.func3)
      3'b000:  cond = (bus.rs1 == bus.rs2);
      3'b001:  cond = (bus.rs1 != bus.rs2);
      3'b100:  cond = ($signed(bus.rs1) < $signed(bus.rs2));
      3'b101:  cond = ($signed(bus.rs1) >= $signed(bus.rs2));
      3'b110:  cond = (bus.rs1 < bus.rs2);
      3'b111:  cond = (bus.rs1 >= bus.rs2);
      default: illegal = 1'b1;
    endcase
    target         = bus.pc + bus.imm;
    fall           = bus.pc + XLEN'(4);
    res.taken      = cond;
    res.next_pc    = cond ? target : fall;
    res.mispredict = cond ^ bus.pred_taken;
    res.illegal    = illegal;
  end

  // A stage can load if it is empty or every stage after it drains
  for (genvar g = 0; g < STAGES; g++) begin : g_rdy
    assign rdy[g] = bus.out_ready
                  || (valid_q[STAGES-1:g] != '1);
  end

  // Shift beats forward where the next stage accepts; flush kills all
  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    if (rdy[0]) begin
      valid_d[0] = bus.in_valid;
      pay_d[0]   = res;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (rdy[i]) begin
        valid_d[i] = valid_q[i-1];
        pay_d[i]   = pay_q[i-1];
      end
    end
    if (bus.flush) begin
      valid_d = '0;
    end
  end

  // Stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        pay_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
    end
  end

  assign bus.in_ready       = rdy[0];
  assign bus.out_valid      = valid_q[STAGES-1];
  assign bus.out_taken      = pay_q[STAGES-1].taken;
  assign bus.out_next_pc    = pay_q[STAGES-1].next_pc;
  assign bus.out_mispredict = pay_q[STAGES-1].mispredict;
  assign bus.out_illegal    = pay_q[STAGES-1].illegal;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] br_q;
  logic [CNT_W-1:0] br_d;
  logic [CNT_W-1:0] tk_q;
  logic [CNT_W-1:0] tk_d;
  logic [CNT_W-1:0] mp_q;
  logic [CNT_W-1:0] mp_d;
  logic             fire;

  assign fire = valid_q[STAGES-1] && bus.out_ready
             && !pay_q[STAGES-1].illegal;

  // Count legal branches as they leave the unit
  always_comb begin
    br_d = br_q;
    tk_d = tk_q;
    mp_d = mp_q;
    if (fire) begin
      br_d = br_q + CNT_W'(1);
      if (pay_q[STAGES-1].taken) begin
        tk_d = tk_q + CNT_W'(1);
      end
      if (pay_q[STAGES-1].mispredict) begin
        mp_d = mp_q + CNT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q <= '0;
      tk_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_d;
      tk_q <= tk_d;
      mp_q <= mp_d;
    end
  end

  assign bus.stat_branches   = br_q;
  assign bus.stat_taken      = tk_q;
  assign bus.stat_mispredict = mp_q;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Pipelined branch resolution unit for the RV32I core; successor to the single-cycle branch comparator.
- Evaluates all six conditional-branch conditions (signed and unsigned) and computes the branch target and fall-through PC.
- Flags mispredictions against the fetch-stage prediction.
- Sits between decode/register-read and the PC-select logic, with a valid/ready handshake on both sides and a pipeline flush input.

Parameters:
- XLEN, 32, operand/PC width in bits (>=8).
- STAGES, 1, number of register stages between input and output (1..4).
- CNT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- func3  input  3  branch funct3 field.
- rs1  input  XLEN  first source operand.
- rs2  input  XLEN  second source operand.
- pc  input  XLEN  PC of the branch instruction.
- imm  input  XLEN  sign-extended B-immediate.
- pred_taken  input  1  fetch-stage prediction.
- flush  input  1  kill all in-flight beats.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_taken  output  1  branch condition true.
- out_next_pc  output  XLEN  resolved next PC.
- out_mispredict  output  1  out_taken != pred_taken.
- out_illegal  output  1  func3 not a branch encoding.

Behaviour:
- Condition encodings:
  - BEQ 000: rs1 == rs2.
  - BNE 001: rs1 != rs2.
  - BLT 100: signed rs1 < rs2.
  - BGE 101: signed rs1 >= rs2.
  - BLTU 110: unsigned rs1 < rs2.
  - BGEU 111: unsigned rs1 >= rs2.
- func3 010/011: out_taken=0, out_illegal=1, out_mispredict=pred_taken.
- Exactly one condition is evaluated per beat, selected by func3; no overlapping or overwriting assignments.
- Target = (pc + imm) mod 2^XLEN; fall-through = (pc + 4) mod 2^XLEN; out_next_pc = taken ? target : fall-through. Both wrap silently, with no overflow flag.
- Pipeline structure:
  - The pipeline is STAGES registers deep, each holding a valid bit plus payload.
  - Condition and sums are computed combinationally before stage 1; later stages carry the result forward.
- Handshake and latency:
  - ready_i = !valid_i || ready_(i+1); ready of the last stage = out_ready; in_ready = ready_1.
  - A beat transfers on in_valid && in_ready. Its result appears on out_valid exactly STAGES cycles later if there are no stalls.
  - Throughput is one beat per cycle while out_ready=1.
  - Under stall (out_valid && !out_ready), all output fields are held stable and no beat is lost or duplicated.
- Flush:
  - flush=1 at a rising edge clears every stage valid bit.
  - An input beat presented in the same cycle is discarded, even though in_ready may read 1.
  - out_valid=0 in the following cycle; payload registers need not be cleared.
- Reset:
  - Asynchronous reset clears all valid bits immediately.
  - Reset values: out_valid=0, out_taken=0, out_next_pc=0, out_mispredict=0, out_illegal=0, in_ready=1 after reset deasserts.
  - Reset mid-operation drops all in-flight beats.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid or the data inputs to any out_* port when STAGES>=1.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds outputs stat_branches, stat_taken, stat_mispredict, each CNT_W wide.
  - Each counter increments by one per beat accepted at the output (out_valid && out_ready) for: all non-illegal branches / those with out_taken=1 / those with out_mispredict=1.
  - Illegal beats are counted by none of the counters.
  - Counters wrap at 2^CNT_W, reset to 0 on rst, and are unaffected by flush (flushed beats never reach the output).
- Undefined: the ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- BEQ, rs1=rs2=0x0000_1234, pc=0x100, imm=0x20, pred_taken=0, STAGES=1, out_ready=1 -> one cycle later: out_taken=1, out_next_pc=0x120, out_mispredict=1.
- BLT vs BLTU, rs1=0xFFFF_FFFF, rs2=0x1 -> BLT: taken=1; BLTU: taken=0, out_next_pc=pc+4.
- Wrap-around: pc=0xFFFF_FFFC, imm=0x8, BNE with rs1!=rs2 -> out_next_pc=0x0000_0004. Same pc with BNE not taken -> out_next_pc=0x0.
- STAGES=3, five back-to-back beats, out_ready held low cycles 4-6 -> all five results appear in order, unchanged while stalled, with in_ready=0 once all stages are full.
- Flush: two beats in flight plus a third presented with flush=1 -> out_valid=0 next cycle and no result ever appears for any of the three. A beat sent on the following cycle completes normally.
- func3=010, pred_taken=1 -> out_illegal=1, out_taken=0, out_mispredict=1. With BRANCH_STATS_EN, stat_branches is unchanged by this beat and stat_mispredict increments only for legal beats; rst mid-stream zeroes all counters and out_valid asynchronously.
